can_bit_timing: RTL

CAN_BIT_TIMING -- requirements
Module: can_bit_timing

---
 rtl/can_bit_timing.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/can_bit_timing.sv
// CAN bit timing recovery.
//
// Synchronizes the raw bus level, hard-syncs on a recessive-to-dominant edge
// while the bus is idle, and resynchronizes on later falling edges by up to
// SJW quanta. It samples the bit once per bit time at SAMPLE_POINT. Eleven
// consecutive recessive samples return the block to idle.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles (time quanta) per CAN bit
//   SAMPLE_POINT  quantum index at which the bit is sampled (1..CLKS_PER_BIT-2)
//   SJW           synchronization jump width in quanta (1..4)
//
// Ports:
//   Clock_TB       in   system clock, rising edge
//   Reset          in   asynchronous, active-high reset
//   Rx_Input       in   raw bus level (1 = recessive, 0 = dominant), asynchronous
//   Sample_Strobe  out  one-cycle pulse in the sample cycle
//   Bit_Output     out  most recently sampled bit, held between strobes
//   Bus_Idle       out  high while the bus is idle
module can_bit_timing #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned SAMPLE_POINT = 7,
    parameter int unsigned SJW          = 1
) (
    input  logic Clock_TB,
    input  logic Reset,
    input  logic Rx_Input,
    output logic Sample_Strobe,
    output logic Bit_Output,
    output logic Bus_Idle
);

    localparam int unsigned TqWidth = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TqWidth-1:0] TqSample = TqWidth'(SAMPLE_POINT);
    localparam logic [TqWidth-1:0] TqLast   = TqWidth'(CLKS_PER_BIT - 1);
    localparam logic [TqWidth-1:0] TqOne    = TqWidth'(1);
    localparam logic [3:0]         IdleBits = 4'd11;

    typedef enum logic {StIdle, StRun} state_t;

    logic               sync_1;
    logic               rx_sync;
    logic               rx_prev;
    logic [1:0]         sync_valid;
    state_t             state;
    state_t             state_d;
    logic [TqWidth-1:0] tq_count;
    logic [TqWidth-1:0] tq_d;
    logic [3:0]         rec_count;
    logic [3:0]         rec_inc;
    logic               resync_used;
    logic               edge_det;
    logic               hard_sync;
    logic               resync_ok;
    logic               idle_hit;
    int unsigned        c;
    int unsigned        jump;
    int unsigned        early_sum;

    always_comb begin
        edge_det  = rx_prev & ~rx_sync;
        hard_sync = (state == StIdle) && edge_det;
        // Sample_Strobe is registered from the same next-state values, so it is
        // high exactly when state is RUN and tq_count == SAMPLE_POINT. The
        // strobe cycle opens a new resync window, so an edge in it is allowed
        // even if the previous window already used its resync.
        resync_ok = (state == StRun) && edge_det && (tq_count != '0) &&
                    (!resync_used || Sample_Strobe);
        rec_inc   = (rec_count == 4'hF) ? 4'hF : rec_count + 4'd1;
        idle_hit  = Sample_Strobe && rx_sync && (rec_inc >= IdleBits);

        c         = 32'(tq_count);
        jump      = 0;
        early_sum = 0;
        state_d   = state;
        tq_d      = '0;

        if (state == StIdle) begin
            // Hard sync: the edge cycle itself is quantum 0.
            if (edge_det) begin
                state_d = StRun;
                tq_d    = TqOne;
            end
        end else if (idle_hit) begin
            state_d = StIdle;
            tq_d    = '0;
        end else if (resync_ok) begin
            if (c <= SAMPLE_POINT) begin
                // Late edge: stretch the phase before the sample point.
                jump = (c < SJW) ? c : SJW;
                tq_d = TqWidth'(c + 1 - jump);
            end else begin
                // Early edge: skip ahead, shortening the current bit.
                jump      = ((CLKS_PER_BIT - c) < SJW) ? (CLKS_PER_BIT - c) : SJW;
                early_sum = c + 1 + jump;
                if (early_sum >= CLKS_PER_BIT) begin
                    early_sum = early_sum - CLKS_PER_BIT;
                end
                tq_d = TqWidth'(early_sum);
            end
        end else begin
            tq_d = (tq_count == TqLast) ? '0 : tq_count + TqOne;
        end
    end

    always_ff @(posedge Clock_TB or posedge Reset) begin
        if (Reset) begin
            sync_1        <= 1'b1;
            rx_sync       <= 1'b1;
            rx_prev       <= 1'b0;
            sync_valid    <= 2'b00;
            state         <= StIdle;
            tq_count      <= '0;
            rec_count     <= 4'd0;
            resync_used   <= 1'b0;
            Sample_Strobe <= 1'b0;
            Bit_Output    <= 1'b1;
            Bus_Idle      <= 1'b1;
        end else begin
            sync_1     <= Rx_Input;
            rx_sync    <= sync_1;
            sync_valid <= {sync_valid[0], 1'b1};
            // The reset value of the synchronizer is not a real bus level. Hold
            // the edge reference low until real data has reached rx_sync, so a
            // bus already dominant at reset release is not taken as an edge.
            rx_prev    <= sync_valid[1] & rx_sync;

            state         <= state_d;
            tq_count      <= tq_d;
            Sample_Strobe <= (state_d == StRun) && (tq_d == TqSample);

            if (Sample_Strobe) begin
                Bit_Output <= rx_sync;
                rec_count  <= rx_sync ? rec_inc : 4'd0;
            end

            if (hard_sync) begin
                Bus_Idle <= 1'b0;
            end else if (idle_hit) begin
                Bus_Idle <= 1'b1;
            end

            if (hard_sync || idle_hit) begin
                resync_used <= 1'b0;
            end else if (resync_ok) begin
                resync_used <= 1'b1;
            end else if (Sample_Strobe) begin
                resync_used <= 1'b0;
            end
        end
    end

endmodule
